// File: rtl/writeback_queue_pkg.sv
// Shared widths, constants and the pending-write entry type for the writeback queue.
package writeback_queue_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;
  localparam int WBQ_DEPTH = 4;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [REG_DATA_W-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/writeback_queue_wb_fifo.sv
// Synchronous pending-write FIFO; also exposes which slots are live and their
// destination registers so the decode stage can check for hazards.
module wb_fifo
  import writeback_queue_pkg::*;
#(
  parameter int DEPTH = WBQ_DEPTH,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  push_i,
  input  wb_entry_t                             push_entry_i,
  input  logic                                  pop_i,
  output wb_entry_t                             head_o,
  output logic [CW-1:0]                         count_o,
  output logic                                  full_o,
  output logic [DEPTH-1:0]                      occ_vld_o,
  output logic [DEPTH-1:0][REG_ADDR_W-1:0]      occ_addr_o
);
  wb_entry_t        mem_q [DEPTH];
  logic [PW-1:0]    head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && (count_q != '0);
  assign head_o  = mem_q[head_q];
  assign count_o = count_q;

  // Pointer and occupancy next-state; pointers wrap naturally at power-of-two depth.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (do_push) tail_d = tail_q + PW'(1);
    if (do_pop)  head_d = head_q + PW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer/occupancy registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage; contents are only meaningful while occupied, so no reset.
  always_ff @(posedge clk) begin
    if (do_push && !rst) mem_q[tail_q] <= push_entry_i;
  end

  // A slot is live when its distance from head is below the occupancy count.
  for (genvar i = 0; i < DEPTH; i++) begin : g_occ
    logic [PW-1:0] off;
    assign off           = PW'(i) - head_q;
    assign occ_vld_o[i]  = (CW'(off) < count_q);
    assign occ_addr_o[i] = mem_q[i].addr;
  end
endmodule

// File: rtl/writeback_queue.sv
// Register-file writeback queue: arbitrates ALU/load results (loads win),
// drops writes to r0, drains one entry per cycle into registered write outputs,
// and flags decode-stage hazards against every pending write.
module writeback_queue
  import writeback_queue_pkg::*;
#(
  parameter int DEPTH = WBQ_DEPTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      aluValid,
  input  logic [REG_ADDR_W-1:0]     aluAddr,
  input  logic [REG_DATA_W-1:0]     aluData,
  output logic                      aluReady,
  input  logic                      memValid,
  input  logic [REG_ADDR_W-1:0]     memAddr,
  input  logic [REG_DATA_W-1:0]     memData,
  output logic                      memReady,
  output logic [REG_ADDR_W-1:0]     wAddr,
  output logic [REG_DATA_W-1:0]     wrData,
  output logic                      regWriteFlag,
  input  logic [REG_ADDR_W-1:0]     rAddr1,
  input  logic [REG_ADDR_W-1:0]     rAddr2,
  output logic                      hazard1,
  output logic                      hazard2,
  output logic [$clog2(DEPTH):0]    count
);
  localparam int CW = $clog2(DEPTH) + 1;

  wb_entry_t                          sel_entry, head;
  logic                               full, mem_acc, alu_acc, push, pop;
  logic [CW-1:0]                      cnt;
  logic [DEPTH-1:0]                   occ_vld;
  logic [DEPTH-1:0][REG_ADDR_W-1:0]   occ_addr;
  logic [REG_ADDR_W-1:0]              wAddr_q, wAddr_d;
  logic [REG_DATA_W-1:0]              wrData_q, wrData_d;
  logic                               flag_q, flag_d;

  assign memReady = !full;
  assign aluReady = !full && !memValid;
  assign mem_acc  = memValid && memReady;
  assign alu_acc  = aluValid && aluReady;

  // Pick the accepted offer; r0 writes handshake but never enter the queue.
  always_comb begin
    sel_entry = '{addr: aluAddr, data: aluData};
    if (mem_acc) sel_entry = '{addr: memAddr, data: memData};
  end
  assign push = (mem_acc || alu_acc) && (sel_entry.addr != REG_ZERO);
  assign pop  = (cnt != '0);

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .push_i       (push),
    .push_entry_i (sel_entry),
    .pop_i        (pop),
    .head_o       (head),
    .count_o      (cnt),
    .full_o       (full),
    .occ_vld_o    (occ_vld),
    .occ_addr_o   (occ_addr)
  );

  // Next write-port values: load the head on a pop, otherwise hold and idle.
  always_comb begin
    wAddr_d  = wAddr_q;
    wrData_d = wrData_q;
    flag_d   = 1'b0;
    if (pop) begin
      wAddr_d  = head.addr;
      wrData_d = head.data;
      flag_d   = 1'b1;
    end
  end

  // Registered register-file write port.
  always_ff @(posedge clk) begin
    if (rst) begin
      wAddr_q  <= '0;
      wrData_q <= '0;
      flag_q   <= 1'b0;
    end else begin
      wAddr_q  <= wAddr_d;
      wrData_q <= wrData_d;
      flag_q   <= flag_d;
    end
  end

  // Hazard: source matches any live entry or the write currently in flight.
  always_comb begin
    hazard1 = flag_q && (wAddr_q == rAddr1);
    hazard2 = flag_q && (wAddr_q == rAddr2);
    for (int i = 0; i < DEPTH; i++) begin
      if (occ_vld[i] && occ_addr[i] == rAddr1) hazard1 = 1'b1;
      if (occ_vld[i] && occ_addr[i] == rAddr2) hazard2 = 1'b1;
    end
    if (rAddr1 == REG_ZERO) hazard1 = 1'b0;
    if (rAddr2 == REG_ZERO) hazard2 = 1'b0;
  end

  assign wAddr        = wAddr_q;
  assign wrData       = wrData_q;
  assign regWriteFlag = flag_q;
  assign count        = cnt;
endmodule
